// File: rtl/bi_mem_wm_arb.sv
// Two-requester round-robin arbiter in front of a masked-write memory.
// Define BI_MEM_ARB_INIT_EN to zero-fill the memory with an INIT sweep after reset.
module bi_mem_wm_arb #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int MASK   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [1:0]                    reqValid_i,
    output logic [1:0]                    reqReady_o,
    input  logic [1:0]                    reqWrite_i,
    input  logic [2*$clog2(HEIGHT)-1:0]   reqAddr_i,
    input  logic [2*MASK-1:0]             reqMask_i,
    input  logic [2*WIDTH-1:0]            reqData_i,
    output logic [1:0]                    rspValid_o,
    output logic [WIDTH-1:0]              rspData_o,
    output logic                          busy_o,
    output logic                          memReadEnable_o,
    output logic [$clog2(HEIGHT)-1:0]     memReadAddr_o,
    input  logic [WIDTH-1:0]              memReadData_i,
    output logic                          memWriteEnable_o,
    output logic [MASK-1:0]               memWriteMask_o,
    output logic [$clog2(HEIGHT)-1:0]     memWriteAddr_o,
    output logic [WIDTH-1:0]              memWriteData_o
);
    localparam int AW = $clog2(HEIGHT);

    logic            run;
    logic            sweeping;
    logic            ptr_q, ptr_d;
    logic [1:0]      rsp_q, rsp_d;
    logic            gnt_any, gnt_idx, sel_write;
    logic [AW-1:0]   sel_addr;
    logic [MASK-1:0] sel_mask;
    logic [WIDTH-1:0] sel_data;

`ifdef BI_MEM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == AW'(HEIGHT - 1)) begin
                state_d = ST_RUN;
                sweep_d = '0;
            end
        end
    end

    always_comb begin
        run      = !rst_i && (state_q == ST_RUN);
        sweeping = !rst_i && (state_q == ST_INIT);
        busy_o   = sweeping;
    end
`else
    always_comb begin
        run      = !rst_i;
        sweeping = 1'b0;
        busy_o   = 1'b0;
    end
`endif

    // Only a lone requester or the pointed-to one of a contending pair is granted.
    always_comb begin
        gnt_any   = run && (|reqValid_i);
        gnt_idx   = (reqValid_i == 2'b11) ? ptr_q : reqValid_i[1];
        sel_write = reqWrite_i[gnt_idx];
        sel_addr  = gnt_idx ? reqAddr_i[2*AW-1:AW]       : reqAddr_i[AW-1:0];
        sel_mask  = gnt_idx ? reqMask_i[2*MASK-1:MASK]   : reqMask_i[MASK-1:0];
        sel_data  = gnt_idx ? reqData_i[2*WIDTH-1:WIDTH] : reqData_i[WIDTH-1:0];
        reqReady_o[0] = gnt_any && !gnt_idx;
        reqReady_o[1] = gnt_any && gnt_idx;
        ptr_d     = gnt_any ? !gnt_idx : ptr_q;
        rsp_d[0]  = gnt_any && !sel_write && !gnt_idx;
        rsp_d[1]  = gnt_any && !sel_write && gnt_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rsp_q <= rsp_d;
        end
    end

    // The registered flag is masked so a response in flight when reset rises never shows.
    always_comb begin
        rspValid_o = rst_i ? 2'b00 : rsp_q;
        rspData_o  = (|rspValid_o) ? memReadData_i : '0;
    end

    always_comb begin
        memReadEnable_o  = 1'b0;
        memReadAddr_o    = '0;
        memWriteEnable_o = 1'b0;
        memWriteMask_o   = '0;
        memWriteAddr_o   = '0;
        memWriteData_o   = '0;
        if (sweeping) begin
            memWriteEnable_o = 1'b1;
            memWriteMask_o   = '1;
`ifdef BI_MEM_ARB_INIT_EN
            memWriteAddr_o   = sweep_q;
`endif
        end else if (gnt_any) begin
            if (sel_write) begin
                memWriteEnable_o = 1'b1;
                memWriteMask_o   = sel_mask;
                memWriteAddr_o   = sel_addr;
                memWriteData_o   = sel_data;
            end else begin
                memReadEnable_o  = 1'b1;
                memReadAddr_o    = sel_addr;
            end
        end
    end

endmodule

// File: tb/tb_bi_mem_wm_arb.sv
// Scoreboard bench for bi_mem_wm_arb with a behavioural memory and reference model.
// Covers both builds; the INIT sweep is expected only when BI_MEM_ARB_INIT_EN is defined.
module tb_bi_mem_wm_arb;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int M  = 4;
    localparam int AW = $clog2(H);
    localparam int LW = W / M;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [1:0]      reqValid_i = '0;
    logic [1:0]      reqReady_o;
    logic [1:0]      reqWrite_i = '0;
    logic [2*AW-1:0] reqAddr_i = '0;
    logic [2*M-1:0]  reqMask_i = '0;
    logic [2*W-1:0]  reqData_i = '0;
    logic [1:0]      rspValid_o;
    logic [W-1:0]    rspData_o;
    logic            busy_o;
    logic            memReadEnable_o;
    logic [AW-1:0]   memReadAddr_o;
    logic [W-1:0]    memReadData_i;
    logic            memWriteEnable_o;
    logic [M-1:0]    memWriteMask_o;
    logic [AW-1:0]   memWriteAddr_o;
    logic [W-1:0]    memWriteData_o;

    bi_mem_wm_arb #(.WIDTH(W), .HEIGHT(H), .MASK(M)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .reqValid_i(reqValid_i), .reqReady_o(reqReady_o), .reqWrite_i(reqWrite_i),
        .reqAddr_i(reqAddr_i), .reqMask_i(reqMask_i), .reqData_i(reqData_i),
        .rspValid_o(rspValid_o), .rspData_o(rspData_o), .busy_o(busy_o),
        .memReadEnable_o(memReadEnable_o), .memReadAddr_o(memReadAddr_o),
        .memReadData_i(memReadData_i),
        .memWriteEnable_o(memWriteEnable_o), .memWriteMask_o(memWriteMask_o),
        .memWriteAddr_o(memWriteAddr_o), .memWriteData_o(memWriteData_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] init_val [H];
    logic [W-1:0] phys     [H];
    logic [W-1:0] ref_mem  [H];

    // Synchronous memory: registered read data, per-lane write mask.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int unsigned i = 0; i < H; i++) phys[i] <= init_val[i];
        end else if (memWriteEnable_o) begin
            for (int unsigned l = 0; l < M; l++)
                if (memWriteMask_o[l]) phys[memWriteAddr_o][l*LW +: LW] <= memWriteData_o[l*LW +: LW];
        end
        if (memReadEnable_o) memReadData_i <= phys[memReadAddr_o];
    end

    typedef struct { int due; int who; logic [W-1:0] data; } exp_t;
    exp_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: a response is due exactly one cycle after its read grant.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            check("rspValid", 64'(rspValid_o), 64'(2'b01 << e.who));
            check("rspData", 64'(rspData_o), 64'(e.data));
        end else begin
            check("rspValid_idle", 64'(rspValid_o), 64'd0);
            check("rspData_idle", 64'(rspData_o), 64'd0);
        end
    end

    int ptr = 0;
    int sweep_left = 0;
    int sweep_pos = 0;

    task automatic step(input bit rst, input bit [1:0] v, input bit [1:0] w,
                        input int a0, input int a1, input bit [M-1:0] m0, input bit [M-1:0] m1,
                        input bit [W-1:0] d0, input bit [W-1:0] d1);
        int g;
        int a [2];
        bit [M-1:0] m [2];
        bit [W-1:0] d [2];
        a[0] = a0; a[1] = a1; m[0] = m0; m[1] = m1; d[0] = d0; d[1] = d1;
        @(posedge clk);
        #1;
        rst_i      = rst;
        reqValid_i = v;
        reqWrite_i = w;
        reqAddr_i  = {AW'(a1), AW'(a0)};
        reqMask_i  = {m1, m0};
        reqData_i  = {d1, d0};
        if (rst) sbq.delete();
        @(negedge clk);
        if (rst) begin
            check("rst_ready", 64'(reqReady_o), 64'd0);
            check("rst_busy", 64'(busy_o), 64'd0);
            check("rst_re", 64'(memReadEnable_o), 64'd0);
            check("rst_we", 64'(memWriteEnable_o), 64'd0);
            ptr = 0;
            sweep_pos = 0;
`ifdef BI_MEM_ARB_INIT_EN
            sweep_left = H;
`else
            sweep_left = 0;
`endif
        end else if (sweep_left > 0) begin
            check("init_busy", 64'(busy_o), 64'd1);
            check("init_ready", 64'(reqReady_o), 64'd0);
            check("init_re", 64'(memReadEnable_o), 64'd0);
            check("init_we", 64'(memWriteEnable_o), 64'd1);
            check("init_addr", 64'(memWriteAddr_o), 64'(sweep_pos));
            check("init_mask", 64'(memWriteMask_o), 64'hF);
            check("init_data", 64'(memWriteData_o), 64'd0);
            ref_mem[sweep_pos] = '0;
            sweep_pos++;
            sweep_left--;
        end else begin
            check("busy", 64'(busy_o), 64'd0);
            if (v == 2'b00) g = -1;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
            else g = ptr;
            if (g < 0) begin
                check("ready_none", 64'(reqReady_o), 64'd0);
                check("re_none", 64'(memReadEnable_o), 64'd0);
                check("we_none", 64'(memWriteEnable_o), 64'd0);
            end else begin
                check("ready", 64'(reqReady_o), 64'(2'b01 << g));
                ptr = 1 - g;
                if (w[g]) begin
                    check("wr_we", 64'(memWriteEnable_o), 64'd1);
                    check("wr_re", 64'(memReadEnable_o), 64'd0);
                    check("wr_addr", 64'(memWriteAddr_o), 64'(a[g]));
                    check("wr_mask", 64'(memWriteMask_o), 64'(m[g]));
                    check("wr_data", 64'(memWriteData_o), 64'(d[g]));
                    for (int unsigned l = 0; l < M; l++)
                        if (m[g][l]) ref_mem[a[g]][l*LW +: LW] = d[g][l*LW +: LW];
                end else begin
                    exp_t e;
                    check("rd_re", 64'(memReadEnable_o), 64'd1);
                    check("rd_we", 64'(memWriteEnable_o), 64'd0);
                    check("rd_addr", 64'(memReadAddr_o), 64'(a[g]));
                    e.due = cyc + 1;
                    e.who = g;
                    e.data = ref_mem[a[g]];
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 2'b00, 0, 0, '0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < H; i++) begin
            init_val[i] = W'($urandom);
            ref_mem[i]  = init_val[i];
        end
        step(1, 2'b00, 2'b00, 0, 0, '0, '0, '0, '0);
        step(1, 2'b11, 2'b00, 0, 0, '0, '0, '0, '0);
        // Contending reads while a sweep would be running, then a reset pulse at address 7.
        for (int i = 0; i < 7; i++)
            step(0, 2'b11, 2'b00, $urandom_range(0, H-1), $urandom_range(0, H-1), '0, '0, '0, '0);
        step(1, 2'b00, 2'b00, 0, 0, '0, '0, '0, '0);
        idle(H);
        // Both requesters contending right after reset/sweep: grants alternate from 0.
        for (int i = 0; i < 4; i++) step(0, 2'b11, 2'b00, i, i + 8, '0, '0, '0, '0);
        // Masked write then immediate read-back of the same word.
        step(0, 2'b01, 2'b01, 5, 0, 4'hF, '0, 16'h0000, '0);
        step(0, 2'b01, 2'b01, 5, 0, 4'b0011, '0, 16'hABCD, '0);
        step(0, 2'b01, 2'b00, 5, 0, '0, '0, '0, '0);
        // Requester 1 back-to-back reads.
        step(0, 2'b10, 2'b00, 0, 3, '0, '0, '0, '0);
        step(0, 2'b10, 2'b00, 0, 4, '0, '0, '0, '0);
        idle(1);
        // Reset in the cycle after a read grant drops the response.
        step(0, 2'b01, 2'b00, 2, 0, '0, '0, '0, '0);
        step(1, 2'b00, 2'b00, 0, 0, '0, '0, '0, '0);
        idle(H + 1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), 2'($urandom), 2'($urandom),
                 $urandom_range(0, H-1), $urandom_range(0, H-1),
                 M'($urandom), M'($urandom), W'($urandom), W'($urandom));
        end
        idle(3);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bi_mem_wm_arb.md
BI_MEM_WM_ARB -- requirements
Module: bi_mem_wm_arb

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 16, memory word width in bits.
- REQ-002: The block SHALL have parameter HEIGHT, default 16, number of memory words.
- REQ-003: The block SHALL have parameter MASK, default 4, write-mask lanes; WIDTH divisible by MASK; lane i covers bits [(i+1)*WIDTH/MASK-1 : i*WIDTH/MASK].
- REQ-004: The block SHALL have port clk_i, input, 1 bit, the single clock of the block.
- REQ-005: The block SHALL have port rst_i, input, 1 bit, reset, synchronous and active-high.
- REQ-006: The block SHALL have port reqValid_i, input, 2 bits, request valid per requester n (n=0,1).
- REQ-007: The block SHALL have port reqReady_o, output, 2 bits, request accepted per requester.
- REQ-008: The block SHALL have port reqWrite_i, input, 2 bits, 1=write, 0=read.
- REQ-009: The block SHALL have port reqAddr_i, input, 2*$clog2(HEIGHT) bits, address; requester n occupies slice n.
- REQ-010: The block SHALL have port reqMask_i, input, 2*MASK bits, write lane enables.
- REQ-011: The block SHALL have port reqData_i, input, 2*WIDTH bits, write data.
- REQ-012: The block SHALL have port rspValid_o, output, 2 bits, read data valid per requester.
- REQ-013: The block SHALL have port rspData_o, output, WIDTH bits, read data shared by both requesters; qualified by rspValid_o.
- REQ-014: The block SHALL have port busy_o, output, 1 bit, high while the init sweep runs.
- REQ-015: The block SHALL have memory-side ports memReadEnable_o (1 bit), memReadAddr_o ($clog2(HEIGHT) bits) and memReadData_i (WIDTH bits, input).
- REQ-016: The block SHALL have memory-side ports memWriteEnable_o (1 bit), memWriteMask_o (MASK bits), memWriteAddr_o ($clog2(HEIGHT) bits) and memWriteData_o (WIDTH bits); the memory is clocked by clk_i for both ports.

Function
- REQ-017: The block SHALL have the states INIT and RUN; at most one access is granted per cycle.
- REQ-018: In RUN, the grant SHALL go to the only valid requester; when both are valid it SHALL go to the requester named by the round-robin pointer.
- REQ-019: reqReady_o[n] SHALL be combinational, high only for the granted requester; a transfer completes when valid and ready are high on the same edge.
- REQ-020: After each transfer the pointer SHALL move to the other requester; with no transfer the pointer SHALL hold.
- REQ-021: A granted write SHALL drive memWriteEnable_o/Mask/Addr/Data combinationally in the grant cycle; writes produce no response.
- REQ-022: A granted read SHALL drive memReadEnable_o/Addr in the grant cycle.
- REQ-023: rspValid_o[n] SHALL be registered, high exactly one cycle after the read grant, with rspData_o = memReadData_i in that cycle; rspData_o is 0 when neither rspValid_o bit is high.
- REQ-024: Back-to-back grants SHALL give one read response per cycle, in grant order.
- REQ-025: A write to address A followed by a read of A in the next cycle SHALL return the written lanes.
- REQ-026: A requester that drops reqValid_i before it is granted SHALL lose nothing; requests are never queued internally.
- REQ-027: mem*Enable_o SHALL be 0 in every cycle without a grant or sweep write.

Reset
- REQ-028: While rst_i is high, all outputs SHALL be 0, the pointer SHALL be 0 and any in-flight read response SHALL be dropped.
- REQ-029: The first cycle after rst_i falls SHALL be INIT when BI_MEM_ARB_INIT_EN is defined, otherwise RUN.
- REQ-030: Reset asserted mid-sweep SHALL restart the sweep at address 0.

Configuration
- REQ-031: With BI_MEM_ARB_INIT_EN defined, INIT SHALL write all-zero data with an all-ones mask to addresses 0..HEIGHT-1, one per cycle, over HEIGHT cycles.
- REQ-032: During INIT, busy_o SHALL be 1 and reqReady_o SHALL be 2'b00; after address HEIGHT-1 is written the state SHALL become RUN and busy_o SHALL go to 0.
- REQ-033: Without BI_MEM_ARB_INIT_EN, the block SHALL have no INIT state, busy_o SHALL be tied to 0 and there SHALL be no sweep counter.

Verification
- REQ-034: INIT_EN, HEIGHT=16: release reset -> busy_o=1 for 16 cycles, memWriteAddr_o sequence 0..15, memWriteMask_o=4'hF, data 0, then reqReady_o is usable.
- REQ-035: Both requesters valid for 4 cycles after reset -> grants go 0,1,0,1.
- REQ-036: Requester 0 writes 16'hABCD with mask 4'b0011 to address 5 over 16'h0000, then reads address 5 next cycle -> one cycle later rspValid_o=2'b01, rspData_o=16'h00CD.
- REQ-037: Requester 1 reads addresses 3 and 4 on consecutive cycles -> rspValid_o[1] is high for 2 consecutive cycles with memory words 3 then 4.
- REQ-038: rst_i pulsed for 1 cycle at sweep address 7 -> the sweep restarts at 0 and busy_o stays high for a further 16 cycles.
- REQ-039: rst_i asserted in the cycle after a read grant -> no rspValid_o pulse follows.
